// File: rtl/frame_drawer.sv
// frame_drawer: per-frame pixel streamer (erase old ball, four platforms, new ball) for a 160x120 VGA adapter
// Ports: clk, reset (async active-high); start requests a frame and latches prev_ball, curr_ball, color_ball,
// position_plats (7-bit row per platform) and color_plats (3-bit colour per platform).
// x/y/colour/plot stream one registered pixel per clock; busy is high while a frame is in flight; done pulses once at the end.
// Option: define FRAME_DRAWER_ERASE_SKIP_EN to skip the erase pass when the ball has not moved.
module frame_drawer #(
  parameter int BALL_X = 76,
  parameter int PLAT_X0 = 8,
  parameter int PLAT_PITCH = 40,
  parameter int PLAT_W = 16,
  parameter logic [2:0] BG_COLOUR = 3'b000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [7:0]  prev_ball,
  input  logic [7:0]  curr_ball,
  input  logic [2:0]  color_ball,
  input  logic [27:0] position_plats,
  input  logic [11:0] color_plats,
  output logic [7:0]  x,
  output logic [6:0]  y,
  output logic [2:0]  colour,
  output logic        plot,
  output logic        busy,
  output logic        done
);
  typedef enum logic [2:0] {IDLE, ERASE, PLAT, BALL, DONE} state_t;
  state_t state_q;
  logic [7:0] prev_q, curr_q, x_q;
  logic [2:0] cball_q, colour_q, pc_d;
  logic [27:0] rows_q;
  logic [11:0] cols_q;
  logic [4:0] cnt_q;
  logic [1:0] idx_q;
  logic [6:0] y_q;
  logic plot_q, busy_q, done_q, draw_d, skip_d, last_d;
  logic [8:0] px_d, py_d;
`ifdef FRAME_DRAWER_ERASE_SKIP_EN
  assign skip_d = prev_ball == curr_ball;
`else
  assign skip_d = 1'b0;
`endif
  // Pixel coordinates are formed in 9 bits so off-screen ball rows can be detected before truncation.
  always_comb begin
    draw_d = state_q inside {ERASE, PLAT, BALL};
    last_d = cnt_q == 5'(PLAT_W - 1);
    px_d = state_q == PLAT ? 9'(PLAT_X0 + PLAT_PITCH * int'(idx_q) + int'(cnt_q))
                           : 9'(BALL_X + int'(cnt_q[1:0]));
    py_d = state_q == PLAT ? {2'b00, rows_q[7*idx_q +: 7]}
                           : {1'b0, state_q == ERASE ? prev_q : curr_q} + {7'd0, cnt_q[3:2]};
    pc_d = state_q == PLAT ? cols_q[3*idx_q +: 3] : state_q == ERASE ? BG_COLOUR : cball_q;
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      prev_q <= '0;
      curr_q <= '0;
      cball_q <= '0;
      rows_q <= '0;
      cols_q <= '0;
      cnt_q <= '0;
      idx_q <= '0;
      x_q <= '0;
      y_q <= '0;
      colour_q <= '0;
      plot_q <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      x_q <= draw_d ? px_d[7:0] : 8'd0;
      y_q <= draw_d ? py_d[6:0] : 7'd0;
      colour_q <= draw_d ? pc_d : 3'd0;
      plot_q <= draw_d && py_d < 9'd120 && px_d < 9'd160;
      busy_q <= state_q != IDLE;
      done_q <= state_q == DONE;
      case (state_q)
        IDLE: if (start) begin
          prev_q <= prev_ball;
          curr_q <= curr_ball;
          cball_q <= color_ball;
          rows_q <= position_plats;
          cols_q <= color_plats;
          cnt_q <= '0;
          idx_q <= '0;
          state_q <= skip_d ? PLAT : ERASE;
        end
        ERASE, BALL: begin
          cnt_q <= cnt_q == 5'd15 ? 5'd0 : cnt_q + 5'd1;
          state_q <= cnt_q != 5'd15 ? state_q : state_q == ERASE ? PLAT : DONE;
        end
        PLAT: begin
          cnt_q <= last_d ? 5'd0 : cnt_q + 5'd1;
          idx_q <= idx_q + {1'b0, last_d};
          state_q <= last_d && idx_q == 2'd3 ? BALL : PLAT;
        end
        DONE: state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end
  assign x = x_q;
  assign y = y_q;
  assign colour = colour_q;
  assign plot = plot_q;
  assign busy = busy_q;
  assign done = done_q;
endmodule

// File: tb/tb_frame_drawer.sv
// tb_frame_drawer: directed self-checking bench for frame_drawer
module tb_frame_drawer;
`ifdef FRAME_DRAWER_ERASE_SKIP_EN
  localparam bit SKIP = 1'b1;
`else
  localparam bit SKIP = 1'b0;
`endif
  localparam int NC = 110;
  logic clk = 1'b0, reset = 1'b1, start = 1'b0;
  logic [7:0] prev_ball, curr_ball;
  logic [2:0] color_ball;
  logic [27:0] position_plats;
  logic [11:0] color_plats;
  logic [7:0] x;
  logic [6:0] y;
  logic [2:0] colour;
  logic plot, busy, done;
  int total = 0, bad = 0, en, np;
  logic [7:0] rx[0:NC], ex[0:NC];
  logic [6:0] ry[0:NC], ey[0:NC];
  logic [2:0] rc[0:NC], ec[0:NC];
  logic rp[0:NC], rd[0:NC], rb[0:NC], ep[0:NC];
  frame_drawer dut (
    .clk(clk), .reset(reset), .start(start), .prev_ball(prev_ball), .curr_ball(curr_ball),
    .color_ball(color_ball), .position_plats(position_plats), .color_plats(color_plats),
    .x(x), .y(y), .colour(colour), .plot(plot), .busy(busy), .done(done)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic set_defaults();
    prev_ball = 8'd40;
    curr_ball = 8'd41;
    color_ball = 3'b100;
    position_plats = {7'd70, 7'd50, 7'd30, 7'd10};
    color_plats = {3'd5, 3'd3, 3'd2, 3'd1};
  endtask
  task automatic add(input int px, input int py, input logic [2:0] c);
    en++;
    ex[en] = 8'(px);
    ey[en] = 7'(py);
    ec[en] = c;
    ep[en] = py < 120 && px < 160;
  endtask
  task automatic build(input logic [7:0] pv, input logic [7:0] cu, input logic [2:0] cb,
                       input logic [27:0] rows, input logic [11:0] cols);
    en = 0;
    if (!(SKIP && pv == cu))
      for (int r = 0; r < 4; r++) for (int c = 0; c < 4; c++) add(76 + c, int'(pv) + r, 3'd0);
    for (int i = 0; i < 4; i++) for (int k = 0; k < 16; k++) add(8 + 40 * i + k, int'(rows[7*i +: 7]), cols[3*i +: 3]);
    for (int r = 0; r < 4; r++) for (int c = 0; c < 4; c++) add(76 + c, int'(cu) + r, cb);
  endtask
  // Records NC cycles after the start edge; optionally disturbs inputs at mod_at or pulses reset at rst_at.
  task automatic run(input int mod_at, input int rst_at);
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    np = 0;
    for (int k = 1; k <= NC; k++) begin
      @(posedge clk);
      #1;
      rx[k] = x; ry[k] = y; rc[k] = colour; rp[k] = plot; rd[k] = done; rb[k] = busy;
      np += int'(plot);
      if (k == mod_at) begin
        prev_ball = 8'd5; curr_ball = 8'd6; color_ball = 3'd7;
        position_plats = 28'h1234567; color_plats = 12'hABC;
        start = 1'b1;
      end else if (k == mod_at + 1) start = 1'b0;
      if (k == rst_at) begin
        reset = 1'b1;
        #1 check("reset_outputs", {x, y, colour, plot, busy, done}, 32'd0);
        #1 reset = 1'b0;
      end
    end
  endtask
  task automatic compare(input string tag);
    for (int k = 1; k <= NC; k++) begin
      check($sformatf("%s plot[%0d]", tag, k), rp[k], k <= en ? ep[k] : 1'b0);
      if (k <= en && ep[k]) check($sformatf("%s pix[%0d]", tag, k), {rx[k], ry[k], rc[k]}, {ex[k], ey[k], ec[k]});
      check($sformatf("%s done[%0d]", tag, k), rd[k], k == en + 1);
      check($sformatf("%s busy[%0d]", tag, k), rb[k], k <= en + 1);
    end
  endtask
  initial begin
    set_defaults();
    repeat (2) @(posedge clk);
    #1 check("reset_state", {x, y, colour, plot, busy, done}, 32'd0);
    @(negedge clk) reset = 1'b0;
    run(0, 0);
    check("count_plots", np, 96);
    check("first_pixel", {rx[1], ry[1], rc[1]}, {8'd76, 7'd40, 3'd0});
    check("pixel_16", {rx[17], ry[17], rc[17]}, {8'd8, 7'd10, 3'd1});
    check("pixel_79", {rx[80], ry[80], rc[80]}, {8'd143, 7'd70, 3'd5});
    check("last_pixel", {rx[96], ry[96], rc[96]}, {8'd79, 7'd44, 3'd4});
    check("done_97", rd[97], 1'b1);
    check("busy_97", rb[97], 1'b1);
    check("busy_98", rb[98], 1'b0);
    build(8'd40, 8'd41, 3'b100, position_plats, color_plats);
    compare("frame_a");
    curr_ball = 8'd118;
    run(0, 0);
    check("clip_row118", rp[81], 1'b1);
    check("clip_row119", rp[88], 1'b1);
    check("clip_row120", rp[89], 1'b0);
    check("clip_row121", rp[96], 1'b0);
    check("clip_done", rd[97], 1'b1);
    build(8'd40, 8'd118, 3'b100, position_plats, color_plats);
    compare("clip");
    set_defaults();
    build(prev_ball, curr_ball, color_ball, position_plats, color_plats);
    run(40, 0);
    compare("midframe");
    set_defaults();
    run(0, 51);
    for (int k = 52; k <= NC; k++) begin
      check($sformatf("rst done[%0d]", k), rd[k], 1'b0);
      check($sformatf("rst plot[%0d]", k), rp[k], 1'b0);
    end
    run(0, 0);
    compare("after_reset");
    prev_ball = 8'd60; curr_ball = 8'd60;
    run(0, 0);
    check("same_first", {rx[1], ry[1], rc[1]}, SKIP ? {8'd8, 7'd10, 3'd1} : {8'd76, 7'd60, 3'd0});
    check("same_done", SKIP ? rd[81] : rd[97], 1'b1);
    build(8'd60, 8'd60, color_ball, position_plats, color_plats);
    compare("same_pos");
    prev_ball = 8'd59;
    run(0, 0);
    check("moved_count", np, 96);
    build(8'd59, 8'd60, color_ball, position_plats, color_plats);
    compare("moved");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
